// File: rtl/mem_stage.sv
// Memory stage of the pipeline: retires ALU results directly and runs loads and
// stores as a blocking request/response handshake with a bounded wait. A HALT
// freezes the stage until reset.
module mem_stage #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] alu_out,
   input  logic [15:0] st_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic [2:0]  wr_reg,
   input  logic        halt,
   input  logic        branch,
   input  logic [15:0] branch_pc,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   output logic        stall,
   output logic        out_valid,
   output logic        wb_en,
   output logic [2:0]  wb_reg,
   output logic [15:0] wb_data,
   output logic        redirect,
   output logic [15:0] redirect_pc,
   output logic        halted,
   output logic        mem_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE_HALT} state_t;

   // The abort fires in the wait cycle that would bring the counter up to
   // TIMEOUT, so exactly TIMEOUT stall cycles are seen before mem_err.
   localparam logic [4:0] TimeoutLimit = 5'(TIMEOUT);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        memReq_q, memReq_d;
   logic        memWr_q, memWr_d;
   logic [15:0] memAddr_q, memAddr_d;
   logic [15:0] memWdata_q, memWdata_d;
   logic        holdRegW_q, holdRegW_d;
   logic [2:0]  holdReg_q, holdReg_d;
   logic        holdBr_q, holdBr_d;
   logic [15:0] holdBpc_q, holdBpc_d;
   logic        outValid_q, outValid_d;
   logic        wbEn_q, wbEn_d;
   logic [2:0]  wbReg_q, wbReg_d;
   logic [15:0] wbData_q, wbData_d;
   logic        redirect_q, redirect_d;
   logic [15:0] redirectPc_q, redirectPc_d;
   logic        halted_q, halted_d;
   logic        memErr_q, memErr_d;
   logic        timeoutHit;

   assign timeoutHit = (({1'b0, cnt_q} + 5'd1) == TimeoutLimit);

   // Upstream must hold only while a memory access is still outstanding.
   assign stall = (state_q == ACCESS) && !mem_done;

   // Next-state and registered-output logic; pulse outputs default low each cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      memReq_d     = memReq_q;
      memWr_d      = memWr_q;
      memAddr_d    = memAddr_q;
      memWdata_d   = memWdata_q;
      holdRegW_d   = holdRegW_q;
      holdReg_d    = holdReg_q;
      holdBr_d     = holdBr_q;
      holdBpc_d    = holdBpc_q;
      outValid_d   = 1'b0;
      wbEn_d       = 1'b0;
      wbReg_d      = wbReg_q;
      wbData_d     = wbData_q;
      redirect_d   = 1'b0;
      redirectPc_d = redirectPc_q;
      halted_d     = halted_q;
      memErr_d     = memErr_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (halt) begin
                  outValid_d = 1'b1;
                  halted_d   = 1'b1;
                  state_d    = DONE_HALT;
               end else if (mem_read || mem_write) begin
                  state_d    = ACCESS;
                  cnt_d      = 4'd0;
                  memReq_d   = 1'b1;
                  memWr_d    = mem_write;
                  memAddr_d  = alu_out;
                  memWdata_d = st_data;
                  holdRegW_d = reg_write;
                  holdReg_d  = wr_reg;
                  holdBr_d   = branch;
                  holdBpc_d  = branch_pc;
               end else begin
                  outValid_d   = 1'b1;
                  wbData_d     = alu_out;
                  wbReg_d      = wr_reg;
                  wbEn_d       = reg_write;
                  redirect_d   = branch;
                  redirectPc_d = branch_pc;
               end
            end
         end
         ACCESS: begin
            if (mem_done) begin
               state_d      = IDLE;
               memReq_d     = 1'b0;
               memWr_d      = 1'b0;
               outValid_d   = 1'b1;
               wbData_d     = memWr_q ? memAddr_q : mem_rdata;
               wbReg_d      = holdReg_q;
               wbEn_d       = holdRegW_q && !memWr_q;
               redirect_d   = holdBr_q;
               redirectPc_d = holdBpc_q;
            end else if (timeoutHit) begin
               state_d    = IDLE;
               cnt_d      = cnt_q + 4'd1;
               memReq_d   = 1'b0;
               memWr_d    = 1'b0;
               outValid_d = 1'b1;
               memErr_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE_HALT: begin
            state_d = DONE_HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         memReq_q     <= 1'b0;
         memWr_q      <= 1'b0;
         memAddr_q    <= 16'd0;
         memWdata_q   <= 16'd0;
         holdRegW_q   <= 1'b0;
         holdReg_q    <= 3'd0;
         holdBr_q     <= 1'b0;
         holdBpc_q    <= 16'd0;
         outValid_q   <= 1'b0;
         wbEn_q       <= 1'b0;
         wbReg_q      <= 3'd0;
         wbData_q     <= 16'd0;
         redirect_q   <= 1'b0;
         redirectPc_q <= 16'd0;
         halted_q     <= 1'b0;
         memErr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         memReq_q     <= memReq_d;
         memWr_q      <= memWr_d;
         memAddr_q    <= memAddr_d;
         memWdata_q   <= memWdata_d;
         holdRegW_q   <= holdRegW_d;
         holdReg_q    <= holdReg_d;
         holdBr_q     <= holdBr_d;
         holdBpc_q    <= holdBpc_d;
         outValid_q   <= outValid_d;
         wbEn_q       <= wbEn_d;
         wbReg_q      <= wbReg_d;
         wbData_q     <= wbData_d;
         redirect_q   <= redirect_d;
         redirectPc_q <= redirectPc_d;
         halted_q     <= halted_d;
         memErr_q     <= memErr_d;
      end
   end

   assign mem_req     = memReq_q;
   assign mem_wr      = memWr_q;
   assign mem_addr    = memAddr_q;
   assign mem_wdata   = memWdata_q;
   assign out_valid   = outValid_q;
   assign wb_en       = wbEn_q;
   assign wb_reg      = wbReg_q;
   assign wb_data     = wbData_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirectPc_q;
   assign halted      = halted_q;
   assign mem_err     = memErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, a transaction-level reference
// model driving randomized ops, and hand-written reset/halt sequences.
module tb_mem_stage;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] alu_out;
   logic [15:0] st_data;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic [2:0]  wr_reg;
   logic        halt;
   logic        branch;
   logic [15:0] branch_pc;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic        stall;
   logic        out_valid;
   logic        wb_en;
   logic [2:0]  wb_reg;
   logic [15:0] wb_data;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halted;
   logic        mem_err;

   int nCompared = 0;
   int nMismatched = 0;
   logic errModel;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        regW;
      logic [2:0]  wrReg;
      logic [15:0] alu;
      logic [15:0] st;
      logic        br;
      logic [15:0] bpc;
      int          lat;
      logic [15:0] rdata;
      int          expStalls;
      logic        expWbEn;
      logic [15:0] expWbData;
      logic        expRedirect;
      logic        expErr;
      logic        timedOut;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_out(alu_out),
      .st_data(st_data), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .wr_reg(wr_reg), .halt(halt), .branch(branch),
      .branch_pc(branch_pc), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_done(mem_done), .stall(stall), .out_valid(out_valid), .wb_en(wb_en),
      .wb_reg(wb_reg), .wb_data(wb_data), .redirect(redirect),
      .redirect_pc(redirect_pc), .halted(halted), .mem_err(mem_err)
   );

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mkVec(input logic rd, input logic wr, input logic regW,
                                  input logic [2:0] wrReg, input logic [15:0] alu,
                                  input logic [15:0] st, input logic br,
                                  input logic [15:0] bpc, input int lat,
                                  input logic [15:0] rdata, input int expStalls,
                                  input logic expWbEn, input logic [15:0] expWbData,
                                  input logic expRedirect, input logic expErr,
                                  input logic timedOut);
      vec_t v;
      v.rd = rd; v.wr = wr; v.regW = regW; v.wrReg = wrReg; v.alu = alu;
      v.st = st; v.br = br; v.bpc = bpc; v.lat = lat; v.rdata = rdata;
      v.expStalls = expStalls; v.expWbEn = expWbEn; v.expWbData = expWbData;
      v.expRedirect = expRedirect; v.expErr = expErr; v.timedOut = timedOut;
      return v;
   endfunction

   // Reference model: an op's outcome follows from its kind and the memory
   // latency alone; memory that answers within TO wait cycles succeeds.
   function automatic vec_t modelExpect(input vec_t v, input logic errIn);
      vec_t r = v;
      r.expErr = errIn;
      r.timedOut = 1'b0;
      if (!v.rd && !v.wr) begin
         r.expStalls = 0;
         r.expWbEn = v.regW;
         r.expWbData = v.alu;
         r.expRedirect = v.br;
      end else if (v.lat < TO) begin
         r.expStalls = v.lat;
         r.expWbEn = v.regW && !v.wr;
         r.expWbData = v.rd ? v.rdata : v.alu;
         r.expRedirect = v.br;
      end else begin
         r.expStalls = TO;
         r.expWbEn = 1'b0;
         r.expWbData = 16'd0;
         r.expRedirect = 1'b0;
         r.expErr = 1'b1;
         r.timedOut = 1'b1;
      end
      return r;
   endfunction

   // Issues one op from IDLE, plays the memory side, and checks the retirement.
   task automatic applyStimulus(input vec_t v);
      int cycles;
      int stalls;
      logic doneNow;
      in_valid = 1'b1; mem_read = v.rd; mem_write = v.wr; reg_write = v.regW;
      wr_reg = v.wrReg; alu_out = v.alu; st_data = v.st; branch = v.br;
      branch_pc = v.bpc; halt = 1'b0; mem_done = 1'b0;
      #1;
      checkOutput("stallIdle", 16'(stall), 16'd0);
      tick();
      stalls = 0;
      if (v.rd || v.wr) begin
         checkOutput("memReq", 16'(mem_req), 16'd1);
         checkOutput("memAddr", mem_addr, v.alu);
         checkOutput("memWr", 16'(mem_wr), 16'(v.wr));
         if (v.wr) checkOutput("memWdata", mem_wdata, v.st);
         checkOutput("validEarly", 16'(out_valid), 16'd0);
         cycles = 0;
         while (!out_valid && cycles < TO + 4) begin
            in_valid = 1'b1;
            alu_out = 16'($urandom);
            mem_read = 1'($urandom);
            mem_write = 1'b0;
            halt = 1'($urandom);
            doneNow = (cycles == v.lat);
            mem_done = doneNow;
            mem_rdata = v.rdata;
            #1;
            if (stall) stalls++;
            checkOutput("stallComb", 16'(stall), 16'(!doneNow));
            checkOutput("memHold", mem_addr, v.alu);
            tick();
            cycles++;
         end
         in_valid = 1'b0; halt = 1'b0; mem_done = 1'b0;
         checkOutput("retireBound", 16'(out_valid), 16'd1);
         checkOutput("stallCount", 16'(stalls), 16'(v.expStalls));
         checkOutput("memReqDrop", 16'(mem_req), 16'd0);
      end else begin
         in_valid = 1'b0;
      end
      checkOutput("outValid", 16'(out_valid), 16'd1);
      checkOutput("wbEn", 16'(wb_en), 16'(v.expWbEn));
      checkOutput("redirect", 16'(redirect), 16'(v.expRedirect));
      checkOutput("memErr", 16'(mem_err), 16'(v.expErr));
      if (!v.timedOut) begin
         checkOutput("wbData", wb_data, v.expWbData);
         checkOutput("wbReg", 16'(wb_reg), 16'(v.wrReg));
      end
      if (v.expRedirect) checkOutput("redirectPc", redirect_pc, v.bpc);
      tick();
      checkOutput("validPulse", 16'(out_valid), 16'd0);
      checkOutput("wbEnPulse", 16'(wb_en), 16'd0);
      checkOutput("redirectPulse", 16'(redirect), 16'd0);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; alu_out = 16'd0; st_data = 16'd0;
      mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; wr_reg = 3'd0;
      halt = 1'b0; branch = 1'b0; branch_pc = 16'd0; mem_rdata = 16'd0;
      mem_done = 1'b0;
      tick(); tick();
      checkOutput("rstMemReq", 16'(mem_req), 16'd0);
      checkOutput("rstMemWr", 16'(mem_wr), 16'd0);
      checkOutput("rstMemAddr", mem_addr, 16'd0);
      checkOutput("rstOutValid", 16'(out_valid), 16'd0);
      checkOutput("rstWbEn", 16'(wb_en), 16'd0);
      checkOutput("rstWbData", wb_data, 16'd0);
      checkOutput("rstRedirect", 16'(redirect), 16'd0);
      checkOutput("rstHalted", 16'(halted), 16'd0);
      checkOutput("rstMemErr", 16'(mem_err), 16'd0);
      checkOutput("rstStall", 16'(stall), 16'd0);
      rst = 1'b1;
      tick();

      tbl[0] = mkVec(0, 0, 1, 3'd3, 16'h1234, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1234, 0, 0, 0);
      tbl[1] = mkVec(0, 0, 0, 3'd1, 16'h5555, 16'h0000, 1, 16'h0100, 0, 16'h0000, 0, 0, 16'h5555, 1, 0, 0);
      tbl[2] = mkVec(1, 0, 1, 3'd5, 16'h0040, 16'h0000, 0, 16'h0000, 3, 16'hBEEF, 3, 1, 16'hBEEF, 0, 0, 0);
      tbl[3] = mkVec(0, 1, 1, 3'd2, 16'h0010, 16'hAAAA, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 0, 0, 0);
      tbl[4] = mkVec(1, 0, 1, 3'd7, 16'h0123, 16'h0000, 0, 16'h0000, 14, 16'h7E57, 14, 1, 16'h7E57, 0, 0, 0);
      tbl[5] = mkVec(0, 1, 0, 3'd4, 16'h0200, 16'h1111, 1, 16'h0300, 2, 16'hDEAD, 2, 0, 16'h0200, 1, 0, 0);
      tbl[6] = mkVec(1, 0, 1, 3'd6, 16'h0080, 16'h0000, 1, 16'h0400, 99, 16'hFFFF, 15, 0, 16'h0000, 0, 1, 1);
      for (int i = 0; i < 7; i++) applyStimulus(tbl[i]);

      // Reset in the second wait cycle of a load discards it.
      in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_out = 16'h0040;
      reg_write = 1'b1; branch = 1'b0; mem_done = 1'b0;
      tick();
      in_valid = 1'b0;
      checkOutput("midMemReq", 16'(mem_req), 16'd1);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkOutput("midRstMemReq", 16'(mem_req), 16'd0);
      checkOutput("midRstValid", 16'(out_valid), 16'd0);
      checkOutput("midRstErr", 16'(mem_err), 16'd0);
      checkOutput("midRstStall", 16'(stall), 16'd0);
      tick();
      checkOutput("midRstValid2", 16'(out_valid), 16'd0);
      applyStimulus(tbl[0]);

      // Randomized ops with idle gaps carrying stray mem_done.
      errModel = 1'b0;
      for (int n = 0; n < 60; n++) begin
         vec_t v;
         int gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            mem_done = 1'($urandom);
            tick();
            checkOutput("gapValid", 16'(out_valid), 16'd0);
            checkOutput("gapMemReq", 16'(mem_req), 16'd0);
         end
         mem_done = 1'b0;
         v.rd = 1'b0; v.wr = 1'b0;
         case ($urandom_range(0, 2))
            0: v.rd = 1'b1;
            1: v.wr = 1'b1;
            default: ;
         endcase
         v.regW = 1'($urandom); v.wrReg = 3'($urandom); v.alu = 16'($urandom);
         v.st = 16'($urandom); v.br = 1'($urandom); v.bpc = 16'($urandom);
         v.rdata = 16'($urandom);
         v.lat = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
         v = modelExpect(v, errModel);
         errModel = v.expErr;
         applyStimulus(v);
      end

      // HALT retires once, then the stage ignores everything.
      in_valid = 1'b1; halt = 1'b1; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b1;
      tick();
      in_valid = 1'b0; halt = 1'b0;
      checkOutput("haltValid", 16'(out_valid), 16'd1);
      checkOutput("haltWbEn", 16'(wb_en), 16'd0);
      checkOutput("haltFlag", 16'(halted), 16'd1);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; mem_read = 1'b1; alu_out = 16'($urandom); mem_done = 1'($urandom);
         #1;
         checkOutput("haltStall", 16'(stall), 16'd0);
         tick();
         checkOutput("haltIgnValid", 16'(out_valid), 16'd0);
         checkOutput("haltIgnReq", 16'(mem_req), 16'd0);
         checkOutput("haltSticky", 16'(halted), 16'd1);
      end
      in_valid = 1'b0; mem_done = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL use a single clock and a synchronous, active-low reset; ports are named clk and rst.
REQ-002 Parameter TIMEOUT, default 15, gives the number of wait cycles before a memory access is aborted.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous reset, active-low.
REQ-005 in_valid  in  1  execute result present this cycle.
REQ-006 alu_out  in  16  ALU result; used as memory address or as writeback value.
REQ-007 st_data  in  16  store data, taken from the execute data_2 pass-through.
REQ-008 mem_read / mem_write  in  1 each  load or store op; never both high.
REQ-009 reg_write  in  1; wr_reg  in  3; halt  in  1: writeback enable, destination register, HALT op.
REQ-010 branch  in  1; branch_pc  in  16: taken-branch flag and target from execute.
REQ-011 mem_req  out  1; mem_wr  out  1; mem_addr  out  16; mem_wdata  out  16: memory request bus.
REQ-012 mem_rdata  in  16; mem_done  in  1: memory response.
REQ-013 stall  out  1  upstream must hold its outputs.
REQ-014 out_valid  out  1; wb_en  out  1; wb_reg  out  3; wb_data  out  16: writeback bundle.
REQ-015 redirect  out  1; redirect_pc  out  16: PC redirect to fetch.
REQ-016 halted  out  1; mem_err  out  1: sticky halt flag and sticky error flag.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE_HALT.
REQ-018 IDLE, in_valid, non-memory op: SHALL register wb_data=alu_out, wb_reg, wb_en=reg_write, redirect=branch and redirect_pc=branch_pc, with out_valid=1 on the next cycle (latency 1).
REQ-019 IDLE, in_valid with mem_read or mem_write:
- captures alu_out, st_data, control and branch into holding registers;
- enters ACCESS;
- out_valid=0 next cycle.
REQ-020 ACCESS: mem_req=1 registered, with mem_addr, mem_wdata and mem_wr (=captured mem_write) held constant until mem_done.
REQ-021 stall SHALL be combinational: 1 when state=ACCESS and mem_done=0; 0 otherwise.
REQ-022 ACCESS with mem_done=1:
- returns to IDLE;
- mem_req=0 next cycle;
- out_valid=1 next cycle;
- wb_data=mem_rdata for a load, captured alu_out for a store;
- wb_en=captured reg_write AND not a store.
REQ-023 Inputs arriving while in ACCESS SHALL be ignored; the upstream holds them under stall.
REQ-024 Wait counter: 4-bit, cleared on entry to ACCESS, increments on each ACCESS cycle without mem_done.
- When the counter reaches TIMEOUT: mem_err=1 (sticky), return to IDLE, out_valid=1, wb_en=0, redirect=0.
REQ-025 mem_done on the same cycle the counter reaches TIMEOUT SHALL count as success; mem_err stays 0.
REQ-026 out_valid, redirect and wb_en SHALL each be single-cycle pulses per retired instruction.
REQ-027 HALT with in_valid in IDLE:
- out_valid=1, wb_en=0 next cycle;
- enters DONE_HALT; halted=1 sticky;
- all further in_valid ignored; stall=0.
REQ-028 mem_done outside ACCESS SHALL be ignored.

Reset
REQ-029 With rst=0 at a clock edge, the block SHALL next cycle be in IDLE with every output 0, the counter at 0, and halted=0, mem_err=0.
REQ-030 A reset during ACCESS SHALL drop mem_req the next cycle and discard the pending instruction (no out_valid).

Verification
REQ-031 ALU op: in_valid, alu_out=0x1234, reg_write=1, wr_reg=3 -> next cycle out_valid=1, wb_data=0x1234, wb_reg=3, stall=0 throughout.
REQ-032 Load: alu_out=0x0040, mem_rdata=0xBEEF, mem_done after 3 wait cycles -> mem_req=1 with mem_addr=0x0040; stall=1 for 3 cycles; then wb_data=0xBEEF, wb_en=1.
REQ-033 Store: alu_out=0x0010, st_data=0xAAAA, mem_done immediately -> mem_wr=1, mem_wdata=0xAAAA, wb_en=0, out_valid=1 pulse.
REQ-034 Timeout: load with mem_done never asserted -> after 15 wait cycles mem_err=1, out_valid=1, wb_en=0, stall=0.
REQ-035 Branch: branch=1, branch_pc=0x0100 -> redirect=1, redirect_pc=0x0100 for exactly one cycle.
REQ-036 Reset mid-access: rst=0 during the 2nd wait cycle -> mem_req=0 and out_valid=0 next cycle; state IDLE.
